// File: rtl/register_file.sv
// register_file: 2^ADDR_W x DATA_W register file with two combinational read
// ports and one synchronous write port. Synchronous active-high reset clears
// every entry and takes priority over a write.
// Optional build macro REGFILE_BYPASS_EN: write-to-read forwarding, so a read
// of the entry being written returns write_data in the same cycle.

// One storage entry: clears on reset, loads on its write select.
module register_file_cell #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] q_q;
  logic [DATA_W-1:0] q_d;

  // Next state: hold unless this entry is selected for write.
  always_comb begin
    q_d = q_q;
    if (we_i) q_d = wdata_i;
  end

  // Entry register; reset wins over any pending write.
  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

module register_file #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] reg1,
  input  logic [ADDR_W-1:0] reg2,
  input  logic [ADDR_W-1:0] reg_w,
  input  logic              do_write,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:0]             wr_sel;

  // One-hot write select decoded from the write index.
  always_comb begin
    wr_sel = '0;
    if (do_write) wr_sel[reg_w] = 1'b1;
  end

  // Array of entries; every index is a plain writable register.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    register_file_cell #(.DATA_W(DATA_W)) u_cell (
      .clk     (clk),
      .reset   (reset),
      .we_i    (wr_sel[g]),
      .wdata_i (write_data),
      .q_o     (regs_q[g])
    );
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd1;
  logic fwd2;

  // Forward write data to a read port addressing the entry being written,
  // except under reset where the array contents are shown.
  always_comb begin
    fwd1 = do_write && !reset && (reg1 == reg_w);
    fwd2 = do_write && !reset && (reg2 == reg_w);
  end

  // Read mux with forwarding.
  always_comb begin
    data1 = fwd1 ? write_data : regs_q[reg1];
    data2 = fwd2 ? write_data : regs_q[reg2];
  end
`else
  // Read mux straight from the array; a same-cycle write shows after the edge.
  always_comb begin
    data1 = regs_q[reg1];
    data2 = regs_q[reg2];
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed cases then random traffic
// against an array model. Honors REGFILE_BYPASS_EN for same-cycle reads.
module tb_register_file;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int NREGS  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] reg1, reg2, reg_w;
  logic              do_write;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] data1, data2;

  logic [DATA_W-1:0] model [NREGS];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .reg1       (reg1),
    .reg2       (reg2),
    .reg_w      (reg_w),
    .do_write   (do_write),
    .write_data (write_data),
    .data1      (data1),
    .data2      (data2)
  );

  task automatic chk(input string tag, input logic [DATA_W-1:0] got,
                     input logic [DATA_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Expected combinational read given current inputs and model contents.
  function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] idx);
`ifdef REGFILE_BYPASS_EN
    if (do_write && !reset && idx == reg_w) return write_data;
`endif
    return model[idx];
  endfunction

  // Apply inputs, check reads before the edge, clock, update model, check after.
  task automatic cyc(input logic rst, input logic we, input logic [ADDR_W-1:0] w,
                     input logic [DATA_W-1:0] wd, input logic [ADDR_W-1:0] r1,
                     input logic [ADDR_W-1:0] r2, input bit pre);
    reset = rst; do_write = we; reg_w = w; write_data = wd; reg1 = r1; reg2 = r2;
    #1;
    if (pre) begin
      chk("pre_d1", data1, exp_rd(r1));
      chk("pre_d2", data2, exp_rd(r2));
    end
    @(posedge clk);
    if (rst) for (int i = 0; i < NREGS; i++) model[i] = '0;
    else if (we) model[w] = wd;
    #1;
    chk("post_d1", data1, model[r1]);
    chk("post_d2", data2, model[r2]);
  endtask

  // Read-only probe without a clock edge.
  task automatic rd(input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2,
                    input string tag);
    reg1 = r1; reg2 = r2; #1;
    chk({tag, "_d1"}, data1, model[r1]);
    chk({tag, "_d2"}, data2, model[r2]);
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    reset = 1'b1; do_write = 1'b0; reg_w = '0; write_data = '0; reg1 = '0; reg2 = '0;
    @(negedge clk);
    // Reset clear with a competing write that must be dropped.
    cyc(1'b1, 1'b1, 2'd1, 8'hCC, 2'd0, 2'd1, 1'b0);
    chk("rst_d1", data1, 8'h00);
    chk("rst_d2", data2, 8'h00);
    // Basic write/read.
    cyc(1'b0, 1'b1, 2'd1, 8'hAA, 2'd1, 2'd2, 1'b1);
    do_write = 1'b0;
    rd(2'd1, 2'd2, "basic");
    chk("basic_aa", data1, 8'hAA);
    // Write disabled.
    cyc(1'b0, 1'b0, 2'd2, 8'h55, 2'd0, 2'd2, 1'b1);
    chk("nowr_d2", data2, 8'h00);
    // Last index, both ports same register.
    cyc(1'b0, 1'b1, 2'd3, 8'hFF, 2'd3, 2'd3, 1'b1);
    do_write = 1'b0;
    rd(2'd3, 2'd3, "same");
    chk("last_d1", data1, 8'hFF);
    chk("last_d2", data2, 8'hFF);
    rd(2'd3, 2'd0, "r0");
    chk("r0_d2", data2, 8'h00);
    // Read-during-write on register 1.
    reset = 1'b0; do_write = 1'b1; reg_w = 2'd1; write_data = 8'h3C; reg1 = 2'd1; reg2 = 2'd0;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("rdw_pre", data1, 8'h3C);
`else
    chk("rdw_pre", data1, 8'hAA);
`endif
    @(posedge clk); model[1] = 8'h3C; #1;
    chk("rdw_post", data1, 8'h3C);
    // Reset mid-operation with a competing write.
    cyc(1'b1, 1'b1, 2'd2, 8'h77, 2'd1, 2'd3, 1'b1);
    do_write = 1'b0; reset = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      reg1 = ADDR_W'(i); #1;
      chk("rstmid", data1, 8'h00);
    end
    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 24) == 0), $urandom_range(0, 1) == 1,
          ADDR_W'($urandom), DATA_W'($urandom), ADDR_W'($urandom),
          ADDR_W'($urandom), 1'b1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
